// File: rtl/semaforo_pkg.sv
// Shared constants for the traffic-light semaphore: phase lengths as multiples of the
// clock frequency, plus the counter-width helper used by every timer.
package semaforo_pkg;

    localparam int unsigned T5_MULT  = 5;
    localparam int unsigned T7_MULT  = 7;
    localparam int unsigned T05_DIV  = 2;

    // Bits needed to hold 0..limit inclusive.
    function automatic int unsigned timer_width(input int unsigned limit);
        longint unsigned span;
        span = longint'(limit) + 64'd1;
        return $clog2(span);
    endfunction

endpackage

// File: rtl/bloco_operativo_if.sv
// Controller <-> datapath strobes and flags of the semaphore, plus the raw
// pedestrian button level.
interface bloco_operativo_if;

    logic pedestrian_btn;
    logic load_Reg5s;
    logic clear_Reg5s;
    logic load_Reg7s;
    logic clear_Reg7s;
    logic load_Reg05s;
    logic clear_Reg05s;
    logic fim_5s;
    logic fim_7s;
    logic fim_05s;
    logic pedestrian;

    modport master (
        output pedestrian_btn,
        output load_Reg5s, clear_Reg5s,
        output load_Reg7s, clear_Reg7s,
        output load_Reg05s, clear_Reg05s,
        input  fim_5s, fim_7s, fim_05s,
        input  pedestrian
    );

    modport slave (
        input  pedestrian_btn,
        input  load_Reg5s, clear_Reg5s,
        input  load_Reg7s, clear_Reg7s,
        input  load_Reg05s, clear_Reg05s,
        output fim_5s, fim_7s, fim_05s,
        output pedestrian
    );

endinterface

// File: rtl/bloco_operativo_temporizador_sat.sv
// Saturating phase timer: counts on load, clears on clear (load wins), and flags
// expiry once the count reaches LIMIT.
module temporizador_sat
    import semaforo_pkg::*;
#(
    parameter int unsigned LIMIT = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    output logic fim
);

    localparam int unsigned W = timer_width(LIMIT);
    localparam logic [W-1:0] LimitW = W'(LIMIT);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            if (cnt_q != LimitW) begin
                cnt_d = cnt_q + W'(1);
            end
        end else if (clear) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Registered decode only; no path from load/clear to fim.
    assign fim = (cnt_q == LimitW);

endmodule

// File: rtl/bloco_operativo.sv
// Semaphore datapath: three saturating phase timers and the pedestrian
// button synchronizer / rising-edge detector.
module bloco_operativo
    import semaforo_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned T5_CYCLES  = T5_MULT * CLK_FREQ,
    parameter int unsigned T7_CYCLES  = T7_MULT * CLK_FREQ,
    parameter int unsigned T05_CYCLES = CLK_FREQ / T05_DIV
) (
    input  logic               clk,
    input  logic               rst,
    bloco_operativo_if.slave   ctrl_io
);

    logic s1_q, s2_q, s3_q;

    temporizador_sat #(.LIMIT(T5_CYCLES)) u_tmr_5s (
        .clk   (clk),
        .rst   (rst),
        .load  (ctrl_io.load_Reg5s),
        .clear (ctrl_io.clear_Reg5s),
        .fim   (ctrl_io.fim_5s)
    );

    temporizador_sat #(.LIMIT(T7_CYCLES)) u_tmr_7s (
        .clk   (clk),
        .rst   (rst),
        .load  (ctrl_io.load_Reg7s),
        .clear (ctrl_io.clear_Reg7s),
        .fim   (ctrl_io.fim_7s)
    );

    temporizador_sat #(.LIMIT(T05_CYCLES)) u_tmr_05s (
        .clk   (clk),
        .rst   (rst),
        .load  (ctrl_io.load_Reg05s),
        .clear (ctrl_io.clear_Reg05s),
        .fim   (ctrl_io.fim_05s)
    );

    // s1/s2 resynchronize the async button; s3 delays s2 for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= ctrl_io.pedestrian_btn;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign ctrl_io.pedestrian = s2_q & ~s3_q;

endmodule

// File: doc/bloco_operativo.md
Name: bloco_operativo

Overview:
Datapath half of the traffic-light semaphore. It owns the three timing counters (red 5 s, green 7 s, yellow 0.5 s). The counters are driven by the controller's load_/clear_ strobes, and the block returns the fim_5s/fim_7s/fim_05s expiry flags. It also conditions the raw pedestrian push-button into a clean one-cycle request pulse for the controller.

Parameters:
CLK_FREQ, 50_000_000, clock frequency in Hz; all timer limits derive from it.
T5_CYCLES, 5*CLK_FREQ, red-phase length in clock cycles.
T7_CYCLES, 7*CLK_FREQ, green-phase length in clock cycles.
T05_CYCLES, CLK_FREQ/2, yellow-phase length in clock cycles; must be >= 1.

Ports:
clk  input  1  system clock, single domain.
rst  input  1  reset, asynchronous and active-high.
pedestrian_btn  input  1  raw push-button level, asynchronous to clk.
load_Reg5s  input  1  count enable for the 5 s timer.
clear_Reg5s  input  1  clear for the 5 s timer.
load_Reg7s  input  1  count enable for the 7 s timer.
clear_Reg7s  input  1  clear for the 7 s timer.
load_Reg05s  input  1  count enable for the 0.5 s timer.
clear_Reg05s  input  1  clear for the 0.5 s timer.
fim_5s  output  1  5 s timer expired.
fim_7s  output  1  7 s timer expired.
fim_05s  output  1  0.5 s timer expired.
pedestrian  output  1  one-cycle synchronized pedestrian request.

Behaviour:
- Reset (async, rst=1): all counters go to 0, all sync flops go to 0, and all four outputs go low immediately. This includes reset asserted mid-count. First count occurs on the first rising edge after rst falls.
- Each timer X in {5s, 7s, 05s} has an unsigned counter cnt_X of width clog2(T_X+1) and limit L_X = T_X_CYCLES.
- Per-edge priority, evaluated at each posedge clk:
  (1) load_X=1: cnt_X <= min(cnt_X+1, L_X). The counter saturates at L_X and never wraps.
  (2) else clear_X=1: cnt_X <= 0.
  (3) else cnt_X holds.
- Load beats clear when both are asserted. The controller asserts load_Reg05s and clear_Reg05s together in yellow, so the 0.5 s timer must count there.
- fim_X = (cnt_X == L_X), decoded from the register only. There is no combinational path from the load/clear inputs to fim_X.
- Latency: from the first edge with load_X=1 on cnt_X=0, fim_X rises after exactly L_X consecutive load edges. fim_X stays high while saturated, and falls one edge after clear_X is sampled with load_X=0.
- A gap in load_X (load=0, clear=0) pauses counting. It is not an error.
- One stale cycle of fim_X high after the controller changes state is expected. The controller ignores fim flags outside their own phase.
- Pedestrian path: three-flop chain s1<=pedestrian_btn, s2<=s1, s3<=s2. pedestrian = s2 & ~s3.
  - Button rising before edge k gives pedestrian high for exactly the cycle between edges k+1 and k+2.
  - Holding the button produces no further pulses. A new pulse needs the synchronized level to return to 0 first.
  - Pulses of the button shorter than one cycle may be missed; this is acceptable.
- Timers are independent. Simultaneous load on several timers is legal and each counts.

Decomposition:
- Shared package semaforo_pkg holds CLK_FREQ-derived cycle constants (T5/T7/T05 multipliers) and the timer-width function.
- Natural sub-module: temporizador_sat. It takes parameter LIMIT and ports clk, rst, load, clear, fim, and is instantiated three times.
- The pedestrian synchronizer/edge detector stays inline.

Test Plan (CLK_FREQ=10, so T5=50, T7=70, T05=5):
1. Reset release, then load_Reg5s held high -> fim_5s low for 49 edges, high after the 50th edge, and remains high while load persists (saturation, no wrap).
2. fim_5s high, then load_Reg5s=0 and clear_Reg5s=1 for one edge -> fim_5s low after that edge and cnt_5s=0.
3. load_Reg05s=1 and clear_Reg05s=1 held together -> fim_05s high after exactly 5 edges (load priority).
4. load_Reg7s high for 30 edges, low with no clear for 10 edges, then high for 40 edges -> fim_7s rises after the 70th load edge, 80 edges total.
5. Assert rst asynchronously mid-count with cnt_7s=40 between edges -> fim_7s and cnt_7s are 0 immediately. After release, a full 70 load edges are needed.
6. pedestrian_btn raised before edge k and held for 20 cycles -> pedestrian high only between edges k+1 and k+2. Release, then re-press -> exactly one new pulse.
